inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp_pkg.sv | 17 +
 rtl/inst_mem_resp_fifo2.sv | 56 +++++
 rtl/inst_mem_resp.sv | 107 ++++++++++
 tb/tb_inst_mem_resp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_resp_pkg.sv
// Shared definitions for the instruction fetch path: default geometry,
// the NOP encoding and the response status type.
package inst_mem_resp_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  // An all-zero word decodes as NOP; cleared memory therefore executes safely.
  localparam logic [DATA_W_DEF-1:0] NOP = '0;

  typedef enum logic {
    RSP_OK  = 1'b0,
    RSP_ERR = 1'b1
  } rsp_status_e;

endpackage

// File: rtl/inst_mem_resp_fifo2.sv
// Two-entry response buffer between the memory read stage and the fetch unit.
// The head is always presented on dout and holds until popped.
module resp_fifo2 #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;
  assign dout  = slot[rd_ptr];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction memory responder: programmable word array with a registered
// read stage feeding a two-entry in-order response buffer.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              active;
  logic              accept;
  logic              pop;
  logic              req_in_range;
  logic              prog_in_range;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  prog_idx;
  logic [DATA_W-1:0] rd_word;
  rsp_status_e       req_status;
  logic [DATA_W:0]   push_entry;
  logic [DATA_W:0]   head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [1:0]        occ;

  assign req_in_range  = ({1'b0, req_addr} < DEPTH_L);
  assign prog_in_range = ({1'b0, prog_addr} < DEPTH_L);
  assign req_idx       = req_addr[IDX_W-1:0];
  assign prog_idx      = prog_addr[IDX_W-1:0];

  // Holds req_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_WORD;
      end
    end else if (prog_we && prog_in_range) begin
      mem[prog_idx] <= prog_data;
    end
  end

  // The read is registered straight into the buffer slot, so the read stage
  // never holds a word of its own and occupancy equals the buffer count.
  always_comb begin
    rd_word    = NOP_WORD;
    req_status = RSP_ERR;
    if (req_in_range) begin
      rd_word    = mem[req_idx];
      req_status = RSP_OK;
    end
  end

  assign push_entry = {req_status, rd_word};
  assign occ        = fifo_count;
  assign pop        = rsp_valid && rsp_ready;
  assign req_ready  = active && ((occ < 2'd2) || pop) && !prog_we;
  assign accept     = req_valid && req_ready;

  resp_fifo2 #(
    .W (DATA_W + 1)
  ) u_resp_fifo2 (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head_entry[DATA_W-1:0];
  assign rsp_err   = head_entry[DATA_W];

  no_overflow_a : assert property (@(posedge clock) disable iff (!reset)
    accept |-> (!fifo_full || pop));

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp (DEPTH = 12): table of per-cycle vectors
// plus a hand-written mid-operation reset sequence.
module tb_inst_mem_resp;

  typedef struct {
    logic       rv;
    logic [3:0] ra;
    logic       rr;
    logic       we;
    logic [3:0] pa;
    logic [3:0] pd;
    logic       e_rdy;
    logic       e_vld;
    logic       chk;
    logic [3:0] e_data;
    logic       e_err;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_addr;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       rsp_ready;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t hand[$];

  inst_mem_resp #(
    .ADDR_W (4),
    .DATA_W (4),
    .DEPTH  (12)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rv, input logic [3:0] ra, input logic rr,
                              input logic we, input logic [3:0] pa, input logic [3:0] pd,
                              input logic e_rdy, input logic e_vld, input logic chk,
                              input logic [3:0] e_data, input logic e_err);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.we = we; v.pa = pa; v.pd = pd;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk = chk; v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs after the falling edge and settles before checking.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    req_valid = v.rv;
    req_addr  = v.ra;
    rsp_ready = v.rr;
    prog_we   = v.we;
    prog_addr = v.pa;
    prog_data = v.pd;
    #1;
  endtask

  task automatic applyAndCheck(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(v.e_rdy));
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.e_vld));
    if (v.chk) begin
      checkOutput({tag, " rsp_data"}, 32'(rsp_data), 32'(v.e_data));
      checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'(v.e_err));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Program, then back-to-back fetch of 0..3.
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'h3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 4'h5, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 4'h7, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 4'h9, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1, 4'h3, 0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 1, 1, 1, 4'h5, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 1, 1, 1, 4'h7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Backpressure: only two accepted, head holds, then drains in order.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 4'h3, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 1, 4'h3, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 1, 4'h3, 0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 1, 1, 1, 4'h3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h5, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    // Out of range (13, 12) and last valid word (11).
    vecs.push_back(mk(1, 13, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1, 4'h0, 1));
    vecs.push_back(mk(1, 11, 1, 0, 0, 0, 1, 1, 1, 4'h5, 0));
    vecs.push_back(mk(1, 12, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    // Write blocks the fetch, fetch next cycle sees new data.
    vecs.push_back(mk(1, 2, 1, 1, 2, 4'hA, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'hA, 0));
    // Buffered responses drain while a write is in progress.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 4'h3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 5, 4'h6, 0, 1, 1, 4'h3, 0));
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 1, 1, 1, 4'h5, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // In reset: everything quiet even with a request offered.
    @(negedge clock);
    @(negedge clock);
    req_valid = 1'b1;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyAndCheck(vecs[i], $sformatf("v%0d", i));
    end

    // Two responses buffered, then reset mid-cycle.
    hand.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    hand.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 4'h3, 0));
    hand.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h3, 0));
    for (int i = 0; i < hand.size(); i++) begin
      applyAndCheck(hand[i], $sformatf("h%0d", i));
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    hand.delete();
    hand.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    hand.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    hand.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0));
    hand.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0));
    hand.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < hand.size(); i++) begin
      applyAndCheck(hand[i], $sformatf("r%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
